// File: rtl/hms_alarm_core_if.sv
// rtl/hms_alarm_core_if.sv - control/display bundle between switch controller, hms_alarm_core and display/buzzer path
interface hms_alarm_core_if #(
  parameter int NUM_ALARMS = 4,
  parameter int AIDX_W     = 2
);
  logic [1:0]            i_mode;
  logic [1:0]            i_field;
  logic                  i_inc;
  logic [AIDX_W-1:0]     i_alarm_idx;
  logic [NUM_ALARMS-1:0] i_alarm_en;
  logic                  i_ack;
  logic                  i_snooze;
  logic [5:0]            o_sec;
  logic [5:0]            o_min;
  logic [4:0]            o_hour;
  logic                  o_tick;
  logic [NUM_ALARMS-1:0] o_ring;

  modport master (
    output i_mode, i_field, i_inc, i_alarm_idx, i_alarm_en, i_ack, i_snooze,
    input  o_sec, o_min, o_hour, o_tick, o_ring
  );

  modport slave (
    input  i_mode, i_field, i_inc, i_alarm_idx, i_alarm_en, i_ack, i_snooze,
    output o_sec, o_min, o_hour, o_tick, o_ring
  );
endinterface

// File: rtl/hms_alarm_core.sv
// rtl/hms_alarm_core.sv - single-clock h:m:s timekeeper with NUM_ALARMS alarm channels (optional snooze: HMS_ALARM_SNOOZE_EN)
module hms_alarm_core #(
  parameter int TICK_DIV   = 50000000,
  parameter int NUM_ALARMS = 4,
  parameter int AIDX_W     = 2,
  parameter int HOUR_MAX   = 23,
  parameter int RING_SEC   = 30
) (
  input logic             clk,
  input logic             rst_n,
  hms_alarm_core_if.slave bus
);
  localparam int            TW    = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]    HMAX  = 5'(HOUR_MAX);
  localparam logic [5:0]    RLAST = 6'(RING_SEC - 1);

`ifdef HMS_ALARM_SNOOZE_EN
  localparam logic [8:0] SLAST = 9'd299;
  typedef enum logic [1:0] {R_IDLE, R_RING, R_SNOOZE} ring_state_t;
`else
  typedef enum logic {R_IDLE, R_RING} ring_state_t;
`endif

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v == HMAX) ? 5'd0 : v + 5'd1;
  endfunction

  logic [TW-1:0] tcnt;
  logic          tick;
  logic          tick_d;
  logic          setup_mode;
  logic          alarm_mode;
  logic [5:0]    sec, min;
  logic [4:0]    hour;

  logic [5:0]    a_sec  [NUM_ALARMS];
  logic [5:0]    a_min  [NUM_ALARMS];
  logic [4:0]    a_hour [NUM_ALARMS];

  ring_state_t           rstate [NUM_ALARMS];
  logic [5:0]            rcnt   [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] ring;
  logic [NUM_ALARMS-1:0] match;
`ifdef HMS_ALARM_SNOOZE_EN
  logic [8:0]            scnt   [NUM_ALARMS];
`else
  logic                  unused_snooze;
  assign unused_snooze = bus.i_snooze;
`endif

  assign setup_mode = (bus.i_mode == 2'b01);
  assign alarm_mode = (bus.i_mode == 2'b10);
  // Gate with setup_mode so a mode change landing on TICK_DIV-1 cannot leak a tick.
  assign tick       = !setup_mode && (tcnt == TLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= '0;
      tick_d <= 1'b0;
      sec    <= '0;
      min    <= '0;
      hour   <= '0;
    end else begin
      tick_d <= tick;
      if (setup_mode || tick) tcnt <= '0;
      else                    tcnt <= tcnt + TW'(1);

      if (tick) begin
        sec <= inc60(sec);
        if (sec == 6'd59) begin
          min <= inc60(min);
          if (min == 6'd59) hour <= inc_hour(hour);
        end
      end else if (setup_mode && bus.i_inc) begin
        case (bus.i_field)
          2'b00:   sec  <= inc60(sec);
          2'b01:   min  <= inc60(min);
          2'b10:   hour <= inc_hour(hour);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        a_sec[k]  <= '0;
        a_min[k]  <= '0;
        a_hour[k] <= '0;
      end
    end else if (alarm_mode && bus.i_inc) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (32'(bus.i_alarm_idx) == k) begin
          case (bus.i_field)
            2'b00:   a_sec[k]  <= inc60(a_sec[k]);
            2'b01:   a_min[k]  <= inc60(a_min[k]);
            2'b10:   a_hour[k] <= inc_hour(a_hour[k]);
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.o_sec  = sec;
    bus.o_min  = min;
    bus.o_hour = hour;
    if (alarm_mode) begin
      bus.o_sec  = '0;
      bus.o_min  = '0;
      bus.o_hour = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (32'(bus.i_alarm_idx) == k) begin
          bus.o_sec  = a_sec[k];
          bus.o_min  = a_min[k];
          bus.o_hour = a_hour[k];
        end
      end
    end
  end

  // Only tick-driven updates can match; tick_d marks the cycle with freshly advanced time.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      match[k] = tick_d && bus.i_alarm_en[k] && (sec == a_sec[k]) &&
                 (min == a_min[k]) && (hour == a_hour[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        rstate[k] <= R_IDLE;
        rcnt[k]   <= '0;
`ifdef HMS_ALARM_SNOOZE_EN
        scnt[k]   <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (match[k]) begin
          rstate[k] <= R_RING;
          ring[k]   <= 1'b1;
          rcnt[k]   <= '0;
        end else begin
          case (rstate[k])
            R_RING: begin
              if (bus.i_ack || !bus.i_alarm_en[k]) begin
                rstate[k] <= R_IDLE;
                ring[k]   <= 1'b0;
`ifdef HMS_ALARM_SNOOZE_EN
              end else if (bus.i_snooze) begin
                rstate[k] <= R_SNOOZE;
                ring[k]   <= 1'b0;
                scnt[k]   <= '0;
`endif
              end else if (tick) begin
                if (rcnt[k] == RLAST) begin
                  rstate[k] <= R_IDLE;
                  ring[k]   <= 1'b0;
                end else begin
                  rcnt[k] <= rcnt[k] + 6'd1;
                end
              end
            end
`ifdef HMS_ALARM_SNOOZE_EN
            R_SNOOZE: begin
              if (bus.i_ack || !bus.i_alarm_en[k]) begin
                rstate[k] <= R_IDLE;
              end else if (tick) begin
                if (scnt[k] == SLAST) begin
                  rstate[k] <= R_RING;
                  ring[k]   <= 1'b1;
                  rcnt[k]   <= '0;
                end else begin
                  scnt[k] <= scnt[k] + 9'd1;
                end
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.o_tick = tick;
  assign bus.o_ring = ring;
endmodule

// File: tb/tb_hms_alarm_core.sv
// tb/tb_hms_alarm_core.sv - directed self-checking bench for hms_alarm_core (TICK_DIV=4, RING_SEC=3)
module tb_hms_alarm_core;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_pass;
  int   n_total;

  hms_alarm_core_if #(.NUM_ALARMS(4), .AIDX_W(3)) bus ();

  hms_alarm_core #(
    .TICK_DIV(4), .NUM_ALARMS(4), .AIDX_W(3), .HOUR_MAX(23), .RING_SEC(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release, as seen at each falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic idle_inputs();
    bus.i_mode = 2'b00; bus.i_field = 2'b11; bus.i_inc = 1'b0; bus.i_alarm_idx = 3'd0;
    bus.i_alarm_en = 4'b0000; bus.i_ack = 1'b0; bus.i_snooze = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic hold_inc(input logic [1:0] f, input int n);
    bus.i_field = f;
    bus.i_inc = 1'b1;
    repeat (n) @(negedge clk);
    bus.i_inc = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_total++; if (bus.o_sec !== 6'd0) $display("FAIL reset_sec: got %0d expected 0", bus.o_sec); else n_pass++;
    n_total++; if (bus.o_min !== 6'd0) $display("FAIL reset_min: got %0d expected 0", bus.o_min); else n_pass++;
    n_total++; if (bus.o_hour !== 5'd0) $display("FAIL reset_hour: got %0d expected 0", bus.o_hour); else n_pass++;
    n_total++; if (bus.o_tick !== 1'b0) $display("FAIL reset_tick: got %0b expected 0", bus.o_tick); else n_pass++;
    n_total++; if (bus.o_ring !== 4'b0) $display("FAIL reset_ring: got %b expected 0000", bus.o_ring); else n_pass++;
    rst_n = 1'b1;
    goto(30);
    n_total++; if (bus.o_sec !== 6'd7) $display("FAIL run_sec7: got %0d expected 7", bus.o_sec); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.o_sec !== 6'd0) $display("FAIL async_reset_sec: got %0d expected 0", bus.o_sec); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tick();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      goto(c);
      n_total++;
      if (bus.o_tick !== ((c % 4) == 3)) $display("FAIL tick_c%0d: got %0b expected %0b", c, bus.o_tick, ((c % 4) == 3));
      else n_pass++;
    end
    goto(236);
    n_total++; if (bus.o_sec !== 6'd59) $display("FAIL tick_sec59: got %0d expected 59", bus.o_sec); else n_pass++;
    goto(240);
    n_total++; if (bus.o_sec !== 6'd0) $display("FAIL tick_sec_wrap: got %0d expected 0", bus.o_sec); else n_pass++;
    n_total++; if (bus.o_min !== 6'd1) $display("FAIL tick_min_carry: got %0d expected 1", bus.o_min); else n_pass++;
  endtask

  task automatic test_setup();
    do_reset();
    bus.i_mode = 2'b01;
    hold_inc(2'b00, 59);
    n_total++; if (bus.o_sec !== 6'd59) $display("FAIL setup_sec59: got %0d expected 59", bus.o_sec); else n_pass++;
    n_total++; if (bus.o_tick !== 1'b0) $display("FAIL setup_no_tick: got %0b expected 0", bus.o_tick); else n_pass++;
    hold_inc(2'b00, 1);
    n_total++; if (bus.o_sec !== 6'd0) $display("FAIL setup_sec_wrap: got %0d expected 0", bus.o_sec); else n_pass++;
    n_total++; if (bus.o_min !== 6'd0) $display("FAIL setup_no_carry: got %0d expected 0", bus.o_min); else n_pass++;
    hold_inc(2'b00, 59);
    hold_inc(2'b01, 59);
    hold_inc(2'b10, 23);
    n_total++; if ({bus.o_hour, bus.o_min, bus.o_sec} !== {5'd23, 6'd59, 6'd59})
      $display("FAIL setup_235959: got %0d:%0d:%0d expected 23:59:59", bus.o_hour, bus.o_min, bus.o_sec); else n_pass++;
    bus.i_mode = 2'b00;
    repeat (3) @(negedge clk);
    n_total++; if (bus.o_tick !== 1'b1) $display("FAIL setup_first_tick: got %0b expected 1", bus.o_tick); else n_pass++;
    n_total++; if (bus.o_sec !== 6'd59) $display("FAIL setup_pre_wrap: got %0d expected 59", bus.o_sec); else n_pass++;
    @(negedge clk);
    n_total++; if ({bus.o_hour, bus.o_min, bus.o_sec} !== 17'd0)
      $display("FAIL day_wrap: got %0d:%0d:%0d expected 0:0:0", bus.o_hour, bus.o_min, bus.o_sec); else n_pass++;
  endtask

  task automatic test_alarm_ring();
    do_reset();
    bus.i_mode = 2'b10; bus.i_alarm_idx = 3'd1;
    hold_inc(2'b00, 5);
    n_total++; if (bus.o_sec !== 6'd5) $display("FAIL alarm1_display: got %0d expected 5", bus.o_sec); else n_pass++;
    bus.i_mode = 2'b00; bus.i_alarm_en = 4'b0010;
    goto(19);
    n_total++; if (bus.o_tick !== 1'b1) $display("FAIL alarm_tick19: got %0b expected 1", bus.o_tick); else n_pass++;
    goto(20);
    n_total++; if (bus.o_ring !== 4'b0000) $display("FAIL ring_early: got %b expected 0000", bus.o_ring); else n_pass++;
    goto(21);
    n_total++; if (bus.o_ring !== 4'b0010) $display("FAIL ring_set: got %b expected 0010", bus.o_ring); else n_pass++;
    goto(31);
    n_total++; if (bus.o_ring !== 4'b0010) $display("FAIL ring_hold: got %b expected 0010", bus.o_ring); else n_pass++;
    goto(32);
    n_total++; if (bus.o_ring !== 4'b0000) $display("FAIL ring_timeout: got %b expected 0000", bus.o_ring); else n_pass++;
  endtask

  task automatic test_setup_no_ring();
    do_reset();
    bus.i_mode = 2'b10; bus.i_alarm_idx = 3'd1; bus.i_field = 2'b00; bus.i_inc = 1'b1;
    goto(5);
    bus.i_mode = 2'b01; bus.i_alarm_en = 4'b0010;
    goto(9);
    bus.i_inc = 1'b0;
    goto(14);
    n_total++; if (bus.o_sec !== 6'd5) $display("FAIL setup_time5: got %0d expected 5", bus.o_sec); else n_pass++;
    n_total++; if (bus.o_ring !== 4'b0000) $display("FAIL setup_no_ring: got %b expected 0000", bus.o_ring); else n_pass++;
  endtask

  task automatic test_ack_same_cycle();
    do_reset();
    bus.i_mode = 2'b10; bus.i_alarm_idx = 3'd1; bus.i_field = 2'b00; bus.i_inc = 1'b1;
    goto(5);
    bus.i_alarm_idx = 3'd2;
    goto(10);
    bus.i_inc = 1'b0; bus.i_mode = 2'b00; bus.i_alarm_en = 4'b0110;
    goto(20);
    bus.i_ack = 1'b1;
    goto(21);
    bus.i_ack = 1'b0;
    n_total++; if (bus.o_ring !== 4'b0110) $display("FAIL set_beats_ack: got %b expected 0110", bus.o_ring); else n_pass++;
    bus.i_alarm_en = 4'b0100;
    goto(22);
    n_total++; if (bus.o_ring !== 4'b0100) $display("FAIL disable_clear: got %b expected 0100", bus.o_ring); else n_pass++;
    bus.i_ack = 1'b1;
    goto(23);
    bus.i_ack = 1'b0;
    n_total++; if (bus.o_ring !== 4'b0000) $display("FAIL ack_clear: got %b expected 0000", bus.o_ring); else n_pass++;
  endtask

  task automatic test_alarm_edit();
    do_reset();
    bus.i_mode = 2'b10; bus.i_alarm_idx = 3'd0; bus.i_field = 2'b01;
    goto(3);
    bus.i_inc = 1'b1;
    goto(4);
    bus.i_inc = 1'b0;
    n_total++; if ({bus.o_hour, bus.o_min, bus.o_sec} !== {5'd0, 6'd1, 6'd0})
      $display("FAIL edit_alarm0: got %0d:%0d:%0d expected 0:1:0", bus.o_hour, bus.o_min, bus.o_sec); else n_pass++;
    bus.i_mode = 2'b00;
    goto(5);
    n_total++; if ({bus.o_hour, bus.o_min, bus.o_sec} !== {5'd0, 6'd0, 6'd1})
      $display("FAIL edit_time: got %0d:%0d:%0d expected 0:0:1", bus.o_hour, bus.o_min, bus.o_sec); else n_pass++;
    bus.i_mode = 2'b10; bus.i_alarm_idx = 3'd5; bus.i_inc = 1'b1;
    goto(6);
    bus.i_inc = 1'b0;
    n_total++; if ({bus.o_hour, bus.o_min, bus.o_sec} !== 17'd0)
      $display("FAIL idx5_display: got %0d:%0d:%0d expected 0:0:0", bus.o_hour, bus.o_min, bus.o_sec); else n_pass++;
    bus.i_alarm_idx = 3'd0;
    goto(7);
    n_total++; if (bus.o_min !== 6'd1) $display("FAIL idx5_no_write: got %0d expected 1", bus.o_min); else n_pass++;
    bus.i_mode = 2'b11;
    goto(8);
    n_total++; if ({bus.o_hour, bus.o_min, bus.o_sec} !== {5'd0, 6'd0, 6'd2})
      $display("FAIL mode11_time: got %0d:%0d:%0d expected 0:0:2", bus.o_hour, bus.o_min, bus.o_sec); else n_pass++;
  endtask

`ifdef HMS_ALARM_SNOOZE_EN
  task automatic test_snooze();
    do_reset();
    bus.i_mode = 2'b10; bus.i_alarm_idx = 3'd0;
    hold_inc(2'b00, 5);
    bus.i_mode = 2'b00; bus.i_alarm_en = 4'b0001;
    goto(21);
    n_total++; if (bus.o_ring !== 4'b0001) $display("FAIL snz_ring: got %b expected 0001", bus.o_ring); else n_pass++;
    goto(22);
    bus.i_snooze = 1'b1;
    goto(23);
    bus.i_snooze = 1'b0;
    n_total++; if (bus.o_ring !== 4'b0000) $display("FAIL snz_clear: got %b expected 0000", bus.o_ring); else n_pass++;
    goto(1219);
    n_total++; if (bus.o_ring !== 4'b0000) $display("FAIL snz_early: got %b expected 0000", bus.o_ring); else n_pass++;
    goto(1220);
    n_total++; if (bus.o_ring !== 4'b0001) $display("FAIL snz_rering: got %b expected 0001", bus.o_ring); else n_pass++;
    bus.i_snooze = 1'b1;
    goto(1221);
    bus.i_snooze = 1'b0;
    goto(1230);
    rst_n = 1'b0;
    #1;
    n_total++; if ({bus.o_ring, bus.o_sec, bus.o_min, bus.o_hour, bus.o_tick} !== 22'd0)
      $display("FAIL snz_reset: got ring=%b t=%0d:%0d:%0d tick=%0b expected all 0", bus.o_ring, bus.o_hour, bus.o_min, bus.o_sec, bus.o_tick);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_tick();
    test_setup();
    test_alarm_ring();
    test_setup_no_ring();
    test_ack_same_cycle();
    test_alarm_edit();
`ifdef HMS_ALARM_SNOOZE_EN
    test_snooze();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
